// File: rtl/mc_rq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_rq_pkg
// Purpose  : Shared types and constants for the MC request queue: MC command
//            codes, the 115-bit queue entry and the flush-sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package mc_rq_pkg;

   // MC request command codes
   localparam logic [2:0] c_CMD_IDLE = 3'd0;
   localparam logic [2:0] c_CMD_RD   = 3'd1;
   localparam logic [2:0] c_CMD_WR   = 3'd2;

   // One queued request; wrd_rdctl is store data or, for loads, read control in [31:0]
   typedef struct packed {
      logic        is_st;
      logic [47:0] vadr;
      logic [1:0]  size;
      logic [63:0] wrd_rdctl;
   } rq_entry_t;

   localparam int RQ_ENTRY_W = $bits(rq_entry_t);

   // Flush sequencer states
   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_DRAIN      = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_WAIT_CMPLT = 2'd3
   } rq_state_t;

endpackage : mc_rq_pkg
`default_nettype wire

// File: rtl/mc_rq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mc_rq_fifo
// Purpose  : Synchronous FIFO with wrapping pointers, occupancy count and
//            full/empty flags. Head entry is presented combinationally.
//            Also exports the next-cycle occupancy so the owner can register
//            occupancy-based flags without a cycle of extra lag.
// Revision : 1.0 - initial release
// ============================================================================
module mc_rq_fifo
   import mc_rq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = RQ_ENTRY_W
) (
   input  logic                       clk,
   input  logic                       i_reset_n,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0]     count_nxt_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             w_wr;
   logic             w_rd;

   assign full_o    = (cnt_q == c_DEPTH);
   assign empty_o   = (cnt_q == '0);
   assign w_wr      = wr_en_i & ~full_o;
   assign w_rd      = rd_en_i & ~empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_nxt_o = cnt_d;

   // Next occupancy from the accepted write/read of this cycle
   always_comb begin
      cnt_d = cnt_q;
      case ({w_wr, w_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule : mc_rq_fifo
`default_nettype wire

// File: rtl/mc_rq_queue.sv
`default_nettype none
// ============================================================================
// Module   : mc_rq_queue
// Purpose  : Per-MC-port request buffer. Queues load/store requests from the
//            vadd pipe, replays them on the MC request bus under mc_rq_stall,
//            and sequences write flushes (drain -> flush -> wait complete).
//            Optional statistics counters enabled by MC_RQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_rq_queue
   import mc_rq_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic        clk,
   input  logic        i_reset_n,
   input  logic        req_ld,
   input  logic        req_st,
   input  logic [63:0] req_wrd_rdctl,
   input  logic [47:0] req_vadr,
   input  logic [1:0]  req_size,
   input  logic        req_flush,
   output logic        req_stall,
   output logic        mc_rq_vld,
   output logic [2:0]  mc_rq_cmd,
   output logic [3:0]  mc_rq_sub,
   output logic [1:0]  mc_rq_len,
   output logic [47:0] mc_rq_vadr,
   output logic [63:0] mc_rq_data,
   output logic [31:0] mc_rq_rtnctl,
   input  logic        mc_rq_stall,
   output logic        mc_rq_flush,
   input  logic        mc_rs_flush_cmplt,
   output logic        flush_done,
   output logic        err_ovf,
   output logic        err_ldst,
   output logic [31:0] stat_ld,
   output logic [31:0] stat_st,
   output logic [31:0] stat_stall
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_AFULL = CNT_W'(AFULL_LVL);

   rq_state_t        state_q, state_d;
   rq_entry_t        w_wr_entry;
   rq_entry_t        w_head;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_full, w_empty;
   logic             w_push_req, w_push, w_pop;
   logic             w_pop_en, w_flush_fire, w_done_fire;

   logic        vld_q;
   logic [2:0]  cmd_q;
   logic [1:0]  len_q;
   logic [47:0] vadr_q;
   logic [63:0] data_q;
   logic [31:0] rtnctl_q;
   logic        flush_q, done_q, req_stall_q, err_ovf_q, err_ldst_q;

   // Exactly one of ld/st makes a request; both together is an error, not a push
   assign w_push_req = req_ld ^ req_st;
   assign w_push     = w_push_req & ~w_full;
   assign w_pop      = ~w_empty & ~mc_rq_stall & w_pop_en;

   assign w_wr_entry = '{is_st: req_st, vadr: req_vadr, size: req_size, wrd_rdctl: req_wrd_rdctl};

   mc_rq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RQ_ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .i_reset_n   (i_reset_n),
      .wr_en_i     (w_push),
      .wr_data_i   (w_wr_entry),
      .rd_en_i     (w_pop),
      .rd_data_o   (w_head),
      .count_nxt_o (w_cnt_nxt),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!i_reset_n) state_q <= ST_RUN;
      else            state_q <= state_d;
   end

   // FSM next state; DRAIN waits for both queue and output register to be idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:        if (req_flush) state_d = ST_DRAIN;
         ST_DRAIN:      if (w_empty && !vld_q && !w_push) state_d = ST_FLUSH;
         ST_FLUSH:      if (!mc_rq_stall) state_d = ST_WAIT_CMPLT;
         ST_WAIT_CMPLT: if (mc_rs_flush_cmplt) state_d = ST_RUN;
         default:       state_d = ST_RUN;
      endcase
   end

   // FSM outputs; issue is held off in FLUSH so a request never shares the flush cycle
   always_comb begin
      w_pop_en     = (state_q != ST_FLUSH);
      w_flush_fire = (state_q == ST_FLUSH) && !mc_rq_stall;
      w_done_fire  = (state_q == ST_WAIT_CMPLT) && mc_rs_flush_cmplt;
   end

   // Output register: one cycle of valid per popped entry, all fields zero when idle
   always_ff @(posedge clk) begin
      if (!i_reset_n || !w_pop) begin
         vld_q    <= 1'b0;
         cmd_q    <= c_CMD_IDLE;
         len_q    <= '0;
         vadr_q   <= '0;
         data_q   <= '0;
         rtnctl_q <= '0;
      end else begin
         vld_q    <= 1'b1;
         cmd_q    <= w_head.is_st ? c_CMD_WR : c_CMD_RD;
         len_q    <= w_head.size;
         vadr_q   <= w_head.vadr;
         data_q   <= w_head.is_st ? w_head.wrd_rdctl : 64'd0;
         rtnctl_q <= w_head.is_st ? 32'd0 : w_head.wrd_rdctl[31:0];
      end
   end

   // Flush/done pulses, registered pipe stall and sticky error flags
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         flush_q     <= 1'b0;
         done_q      <= 1'b0;
         req_stall_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_ldst_q  <= 1'b0;
      end else begin
         flush_q     <= w_flush_fire;
         done_q      <= w_done_fire;
         req_stall_q <= (w_cnt_nxt >= c_AFULL) || (state_d != ST_RUN);
         if (w_push_req && w_full) err_ovf_q  <= 1'b1;
         if (req_ld && req_st)     err_ldst_q <= 1'b1;
      end
   end

   assign mc_rq_vld    = vld_q;
   assign mc_rq_cmd    = cmd_q;
   assign mc_rq_sub    = 4'd0;
   assign mc_rq_len    = len_q;
   assign mc_rq_vadr   = vadr_q;
   assign mc_rq_data   = data_q;
   assign mc_rq_rtnctl = rtnctl_q;
   assign mc_rq_flush  = flush_q;
   assign flush_done   = done_q;
   assign req_stall    = req_stall_q;
   assign err_ovf      = err_ovf_q;
   assign err_ldst     = err_ldst_q;

`ifdef MC_RQ_STATS_EN
   logic [31:0] stat_ld_q, stat_st_q, stat_stall_q;

   // Saturating counters: issued reads, issued writes, stalled cycles with data queued
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         stat_ld_q    <= '0;
         stat_st_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         if (w_pop && !w_head.is_st && (stat_ld_q != 32'hFFFF_FFFF))
            stat_ld_q <= stat_ld_q + 32'd1;
         if (w_pop && w_head.is_st && (stat_st_q != 32'hFFFF_FFFF))
            stat_st_q <= stat_st_q + 32'd1;
         if (!w_empty && mc_rq_stall && (stat_stall_q != 32'hFFFF_FFFF))
            stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_ld    = stat_ld_q;
   assign stat_st    = stat_st_q;
   assign stat_stall = stat_stall_q;
`else
   assign stat_ld    = 32'd0;
   assign stat_st    = 32'd0;
   assign stat_stall = 32'd0;
`endif

endmodule : mc_rq_queue
`default_nettype wire
